// File: rtl/chained_serial_lut_pkg.sv
// Shared sizing helpers and the shift/rotate/hold mode decode for the
// serially loaded LUT bank.
package chained_serial_lut_pkg;

    // Priority-decoded operating mode for one clock cycle.
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'd0,
        MODE_SHIFT = 2'd1,
        MODE_ROT   = 2'd2
    } mode_e;

    // Number of bits held by one table of 2**in_w entries of out_w bits.
    function automatic int table_bits(input int in_w, input int out_w);
        return (2 ** in_w) * out_w;
    endfunction

    // Total length of the daisy chain across n tables.
    function automatic int chain_bits(input int n, input int in_w, input int out_w);
        return n * table_bits(in_w, out_w);
    endfunction

    // Counter width able to hold the values 0..bits inclusive.
    function automatic int cnt_w(input int bits);
        return $clog2(bits + 1);
    endfunction

    // Shift enable always wins over rotate enable.
    function automatic mode_e decode_mode(input logic cs_n, input logic rot_n);
        if (!cs_n) begin
            return MODE_SHIFT;
        end
        if (!rot_n) begin
            return MODE_ROT;
        end
        return MODE_HOLD;
    endfunction

endpackage

// File: rtl/chained_serial_lut_mux_slice.sv
// Combinational entry select from one table slice of the chain.
// Entry i occupies bits [(i+1)*OUT_WIDTH-1 -: OUT_WIDTH] of the slice.
module lut_mux_slice
    import chained_serial_lut_pkg::*;
#(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 3
) (
    input  logic [table_bits(IN_WIDTH, OUT_WIDTH)-1:0] i_table,
    input  logic [IN_WIDTH-1:0]                        i_sel,
    output logic [OUT_WIDTH-1:0]                       o_entry
);

    localparam int NUM_ENTRIES = 2 ** IN_WIDTH;

    logic [OUT_WIDTH-1:0] w_entries [NUM_ENTRIES];

    // Split the flat slice into an addressable entry array.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            assign w_entries[gi] = i_table[gi*OUT_WIDTH +: OUT_WIDTH];
        end
    endgenerate

    // Select the addressed entry.
    always_comb begin
        o_entry = w_entries[i_sel];
    end

endmodule

// File: rtl/chained_serial_lut.sv
// Bank of NUM_LUTS lookup tables loaded through one daisy-chained shift
// register. Tracks whether the current load session has filled the whole
// chain, supports per-table rotation, and exposes the chain tail on dout
// so several tiles can be cascaded.
module chained_serial_lut
    import chained_serial_lut_pkg::*;
#(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 3,
    parameter int NUM_LUTS  = 2,
    parameter int REG_OUT   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          d,
    input  logic                          cs_n,
    input  logic                          rot_n,
    input  logic [NUM_LUTS*IN_WIDTH-1:0]  sel,
    output logic [NUM_LUTS*OUT_WIDTH-1:0] out,
    output logic                          out_valid,
    output logic                          dout,
    output logic                          loaded
);

    localparam int TABLE_BITS = table_bits(IN_WIDTH, OUT_WIDTH);
    localparam int CHAIN_BITS = chain_bits(NUM_LUTS, IN_WIDTH, OUT_WIDTH);
    localparam int CNT_W      = cnt_w(CHAIN_BITS);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CHAIN_BITS-1:0]          r_chain;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_loaded;
    logic                           r_cs_n_q;

    mode_e                          w_mode;
    logic [CHAIN_BITS-1:0]          w_rot_chain;
    logic [CNT_W-1:0]               w_cnt_next;
    logic [NUM_LUTS*OUT_WIDTH-1:0]  w_lookup;

    // Decode this cycle's operation; shift has priority over rotate.
    always_comb begin
        w_mode = decode_mode(cs_n, rot_n);
    end

    // Per-table rotation and lookup. Rotating by one entry moves entry i+1
    // into entry i and wraps entry 0 to the top, i.e. each slice rotates
    // right by OUT_WIDTH bits independently of its neighbours.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LUTS; gi++) begin : g_lut
            assign w_rot_chain[gi*TABLE_BITS +: TABLE_BITS] =
                {r_chain[gi*TABLE_BITS +: OUT_WIDTH],
                 r_chain[gi*TABLE_BITS + OUT_WIDTH +: TABLE_BITS - OUT_WIDTH]};

            lut_mux_slice #(
                .IN_WIDTH  (IN_WIDTH),
                .OUT_WIDTH (OUT_WIDTH)
            ) u_mux (
                .i_table (r_chain[gi*TABLE_BITS +: TABLE_BITS]),
                .i_sel   (sel[gi*IN_WIDTH +: IN_WIDTH]),
                .o_entry (w_lookup[gi*OUT_WIDTH +: OUT_WIDTH])
            );
        end
    endgenerate

    // Chain storage: shift in d at bit 0, rotate tables, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            case (w_mode)
                MODE_SHIFT: r_chain <= {r_chain[CHAIN_BITS-2:0], d};
                MODE_ROT:   r_chain <= w_rot_chain;
                default:    r_chain <= r_chain;
            endcase
        end
    end

    // Saturating increment for continuing sessions.
    always_comb begin
        w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);
    end

    // Session tracking: a shift following a deselected cycle restarts the
    // count; loaded only rises once a single session covers the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_n_q <= 1'b1;
            r_cnt    <= '0;
            r_loaded <= 1'b0;
        end else begin
            r_cs_n_q <= cs_n;
            if (w_mode == MODE_SHIFT) begin
                if (r_cs_n_q) begin
                    r_cnt    <= CNT_ONE;
                    r_loaded <= (CHAIN_BITS == 1);
                end else begin
                    r_cnt    <= w_cnt_next;
                    r_loaded <= (w_cnt_next == CNT_MAX);
                end
            end
        end
    end

    assign dout   = r_chain[CHAIN_BITS-1];
    assign loaded = r_loaded;

    // Output stage: registered lookup of the pre-edge table, or a direct
    // combinational path when REG_OUT is zero.
    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [NUM_LUTS*OUT_WIDTH-1:0] r_out;
            logic                          r_out_valid;

            // Capture the lookup and the loaded state every cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out       <= '0;
                    r_out_valid <= 1'b0;
                end else begin
                    r_out       <= w_lookup;
                    r_out_valid <= r_loaded;
                end
            end

            assign out       = r_out;
            assign out_valid = r_out_valid;
        end else begin : g_comb_out
            assign out       = w_lookup;
            assign out_valid = r_loaded;
        end
    endgenerate

endmodule

// File: doc/chained_serial_lut.md
Name: chained_serial_lut

Overview:
- Multi-channel, serially loaded lookup-table bank: NUM_LUTS independent 2**IN_WIDTH x OUT_WIDTH tables on one daisy-chained shift register.
- Adds load-progress tracking (loaded flag), serial readback/cascade output, optional registered lookup with valid, and per-table rotation.
- Sits directly behind the tile I/O pins; the chain can be extended across tiles through dout.

Parameters:
- IN_WIDTH, 4, select width per LUT; each table has 2**IN_WIDTH entries.
- OUT_WIDTH, 3, bits per table entry.
- NUM_LUTS, 2, number of independent tables/channels.
- REG_OUT, 1, 1 = registered lookup (1-cycle latency); 0 = combinational lookup.
- Derived: TABLE_BITS = 2**IN_WIDTH*OUT_WIDTH; CHAIN_BITS = NUM_LUTS*TABLE_BITS; CNT_W = clog2(CHAIN_BITS+1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d  in  1  serial load data.
- cs_n  in  1  active-low shift enable; has priority over rot_n.
- rot_n  in  1  active-low rotate enable.
- sel  in  NUM_LUTS*IN_WIDTH  select; slice k drives LUT k.
- out  out  NUM_LUTS*OUT_WIDTH  lookup result; slice k from LUT k.
- out_valid  out  1  out is from a fully loaded chain.
- dout  out  1  serial out = chain[CHAIN_BITS-1] (registered bit).
- loaded  out  1  current load session has shifted >= CHAIN_BITS bits.

Behaviour:
- Reset (async): chain=0, bit counter=0, loaded=0, out=0, out_valid=0, cs_n_q=1.
- Mapping: LUT k entry i = chain[k*TABLE_BITS + (i+1)*OUT_WIDTH-1 -: OUT_WIDTH].
  - The first bit shifted lands at the MSB of LUT NUM_LUTS-1 entry 2**IN_WIDTH-1 after CHAIN_BITS shifts.
- Shift (cs_n=0): chain <= {chain[CHAIN_BITS-2:0], d}.
- Session tracking:
  - cs_n_q registers cs_n.
  - Shift cycle with cs_n_q=1 starts a new session: counter <= 1, loaded <= 0 (loaded <= 1 only if CHAIN_BITS==1).
  - Other shift cycles: counter increments, saturating at CHAIN_BITS; loaded <= (next counter == CHAIN_BITS).
- Rotate (cs_n=1, rot_n=0): each table rotates independently by one entry.
  - New entry i = old entry i+1; new top entry = old entry 0.
  - Counter and loaded are unchanged.
- Both cs_n=0 and rot_n=0: shift only.
- Neither active: hold.
- Lookup reads the pre-edge table contents.
  - REG_OUT=1: out <= lookup(sel) every cycle; out_valid <= loaded. Latency 1 cycle.
  - REG_OUT=0: out = lookup(sel) combinationally; out_valid = loaded.
- Early end (cs_n rises before CHAIN_BITS shifts): loaded stays 0. Partial table contents remain usable; out_valid=0.
- Overshift past CHAIN_BITS: counter saturates, loaded stays 1, oldest bits exit on dout.
- Reset mid-session: everything cleared. loaded needs a complete new session.

Decomposition:
- Package chained_serial_lut_pkg:
  - functions table_bits(in_w,out_w), chain_bits(n,in_w,out_w), cnt_w(bits).
  - constants SHIFT/ROT/HOLD mode encodings for the priority decode.
- Sub-module lut_mux_slice: purely combinational entry select from one TABLE_BITS slice.
  - Instantiated NUM_LUTS times in a generate loop.
  - Top holds chain, counter, session logic, rotation and output register.

Test Plan (defaults: TABLE_BITS=48, CHAIN_BITS=96, REG_OUT=1):
- Reset: assert rst_n=0 mid-clock -> out=0, out_valid=0, loaded=0, dout=0 immediately, without a clock edge.
- Full load:
  - Stimulus: shift 96 bits so LUT0 entry i = i[2:0] and LUT1 entry i = ~i[2:0]; loaded=1 on the 96th edge.
  - Then sel0=5, sel1=2 -> one edge later out[2:0]=5, out[5:3]=5, out_valid=1.
- Partial load: new session of 50 bits, then cs_n=1 -> loaded=0, out_valid=0 next edge, counter held at 50.
- Rotate: after full load, rot_n=0 for one cycle, cs_n=1.
  - LUT0 sel=5 -> 6; LUT0 sel=15 -> 0; LUT1 sel=15 -> 7.
  - loaded stays 1.
- Readback/priority:
  - Stimulus: cs_n high then low, cs_n=0 and rot_n=0 together, shift 96 zeros.
  - dout replays the previously loaded stream first-bit-first; no rotation occurs.
  - loaded=0 until the 96th bit, then 1; the table is then all zeros.
- Reset mid-load: rst_n=0 after 40 bits, then a 96-bit session -> loaded rises exactly on bit 96 of the new session.
